fw_wishbone_amo_initiator: RTL and testbench

FW_WISHBONE_AMO_INITIATOR -- requirements
Module: fw_wishbone_amo_initiator

---
 rtl/fw_wishbone_amo_initiator.sv | 172 +++++++++++++++++
 tb/tb_fw_wishbone_amo_initiator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fw_wishbone_amo_initiator.sv
`default_nettype none
// ============================================================================
// Module      : fw_wishbone_amo_initiator
// Description : Single-outstanding Wishbone classic initiator.
//               A request/response handshake front end drives the bus.
//               AMO commands are tagged on i_tgc.
//               Optional watchdog: define FW_WB_AMO_INIT_TIMEOUT_EN to abort
//               a silent bus cycle after TIMEOUT_CYCLES cycles with an error.
// Revision    : 1.0 - initial release
// ============================================================================
module fw_wishbone_amo_initiator #(
    parameter int ADR_WIDTH      = 32,
    parameter int DAT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                   clock,
    input  logic                   reset_n,
    // command channel
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADR_WIDTH-1:0]   req_adr,
    input  logic [DAT_WIDTH-1:0]   req_dat,
    input  logic                   req_we,
    input  logic [DAT_WIDTH/8-1:0] req_sel,
    input  logic [3:0]             req_amo,
    // response channel
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DAT_WIDTH-1:0]   rsp_dat,
    output logic                   rsp_err,
    // Wishbone initiator port
    output logic [ADR_WIDTH-1:0]   i_adr,
    output logic [DAT_WIDTH-1:0]   i_dat_w,
    output logic [DAT_WIDTH/8-1:0] i_sel,
    output logic                   i_we,
    output logic                   i_cyc,
    output logic                   i_stb,
    output logic [3:0]             i_tgc,
    input  logic [DAT_WIDTH-1:0]   i_dat_r,
    input  logic                   i_ack,
    input  logic                   i_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;
    logic target_done;
    logic timeout;
    logic bus_done;

    assign accept      = (state == IDLE) && req_valid;
    // Target responses only count while a cycle is actually on the bus.
    assign target_done = (state == BUS) && (i_ack || i_err);
    assign bus_done    = target_done || timeout;

`ifdef FW_WB_AMO_INIT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wd_cnt;

    // A real ack/err on the limit edge wins over the watchdog.
    assign timeout = (state == BUS) && !(i_ack || i_err) &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on entry to BUS, counts BUS cycles without a response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (accept) begin
            wd_cnt <= '0;
        end else if ((state == BUS) && !(i_ack || i_err) && !timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    // No watchdog: BUS waits for the target indefinitely.
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake/strobe outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        i_cyc      = 1'b0;
        i_stb      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = BUS;
                end
            end
            BUS: begin
                i_cyc = 1'b1;
                i_stb = 1'b1;
                if (bus_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command capture; AMOs always write the full word with the code on i_tgc.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            i_adr   <= '0;
            i_dat_w <= '0;
            i_sel   <= '0;
            i_we    <= 1'b0;
            i_tgc   <= 4'd0;
        end else if (accept) begin
            i_adr   <= req_adr;
            i_dat_w <= req_dat;
            if (req_amo != 4'd0) begin
                i_we  <= 1'b1;
                i_sel <= '1;
                i_tgc <= req_amo;
            end else begin
                i_we  <= req_we;
                i_sel <= req_sel;
                i_tgc <= 4'd0;
            end
        end
    end

    // Response capture at termination; error wins when ack and err coincide.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_dat <= '0;
            rsp_err <= 1'b0;
        end else if (bus_done) begin
            if (target_done) begin
                rsp_dat <= i_dat_r;
                rsp_err <= i_err;
            end else begin
                rsp_dat <= '0;
                rsp_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fw_wishbone_amo_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_fw_wishbone_amo_initiator
// Description : Directed self-checking bench for fw_wishbone_amo_initiator.
//               Expected responses go through a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fw_wishbone_amo_initiator;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam logic [3:0] AMO_ADD = 4'h1;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [AW-1:0] req_adr = '0;
    logic [DW-1:0] req_dat = '0;
    logic          req_we = 1'b0;
    logic [3:0]    req_sel = '0;
    logic [3:0]    req_amo = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_dat;
    logic          rsp_err;
    logic [AW-1:0] i_adr;
    logic [DW-1:0] i_dat_w;
    logic [3:0]    i_sel;
    logic          i_we;
    logic          i_cyc;
    logic          i_stb;
    logic [3:0]    i_tgc;
    logic [DW-1:0] i_dat_r = '0;
    logic          i_ack = 1'b0;
    logic          i_err = 1'b0;

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          err;
    } rsp_t;

    rsp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_adr;

    always #5 clock = ~clock;

    fw_wishbone_amo_initiator #(
        .ADR_WIDTH      (AW),
        .DAT_WIDTH      (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_adr   (req_adr),
        .req_dat   (req_dat),
        .req_we    (req_we),
        .req_sel   (req_sel),
        .req_amo   (req_amo),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .i_adr     (i_adr),
        .i_dat_w   (i_dat_w),
        .i_sel     (i_sel),
        .i_we      (i_we),
        .i_cyc     (i_cyc),
        .i_stb     (i_stb),
        .i_tgc     (i_tgc),
        .i_dat_r   (i_dat_r),
        .i_ack     (i_ack),
        .i_err     (i_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a command in IDLE; return at the first BUS-cycle negedge.
    task automatic issue(input logic [AW-1:0] adr, input logic [DW-1:0] dat, input logic we,
                         input logic [3:0] sel, input logic [3:0] amo,
                         input logic exp_we, input logic [3:0] exp_sel);
        req_valid = 1'b1;
        req_adr   = adr;
        req_dat   = dat;
        req_we    = we;
        req_sel   = sel;
        req_amo   = amo;
        exp_adr   = adr;
        check("req_ready_idle", req_ready, 1);
        @(negedge clock);
        req_valid = 1'b0;
        check("bus_cyc", i_cyc, 1);
        check("bus_stb", i_stb, 1);
        check("bus_req_ready", req_ready, 0);
        check("bus_adr", i_adr, adr);
        check("bus_dat_w", i_dat_w, dat);
        check("bus_we", i_we, exp_we);
        check("bus_sel", i_sel, exp_sel);
        check("bus_tgc", i_tgc, amo);
    endtask

    // Target waits, then terminates with the given ack/err/data.
    task automatic target_respond(input int waits, input logic ack, input logic err,
                                  input logic [DW-1:0] dat);
        rsp_t e;
        for (int i = 0; i < waits; i++) begin
            @(negedge clock);
            check("wait_cyc", i_cyc, 1);
            check("wait_adr_stable", i_adr, exp_adr);
        end
        i_ack   = ack;
        i_err   = err;
        i_dat_r = dat;
        e.dat   = dat;
        e.err   = err;
        sb.push_back(e);
        @(negedge clock);
        i_ack   = 1'b0;
        i_err   = 1'b0;
        i_dat_r = '0;
        check("term_cyc_low", i_cyc, 0);
        check("term_stb_low", i_stb, 0);
        check("term_rsp_valid", rsp_valid, 1);
    endtask

    // Hold off rsp_ready for 'hold' cycles, then accept and score the response.
    task automatic take_response(input int hold);
        rsp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_rsp_dat", rsp_dat, e.dat);
            check("hold_rsp_err", rsp_err, e.err);
            check("hold_req_ready", req_ready, 0);
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        check("rsp_valid", rsp_valid, 1);
        check("rsp_dat", rsp_dat, e.dat);
        check("rsp_err", rsp_err, e.err);
        @(negedge clock);
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 0);
        check("post_req_ready", req_ready, 1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        check("rst_cyc", i_cyc, 0);
        check("rst_stb", i_stb, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_rsp_valid", rsp_valid, 0);
            check("post_rst_cyc", i_cyc, 0);
        end
    endtask

    initial begin
        int n;

        // Reset state
        #2;
        check("reset_cyc", i_cyc, 0);
        check("reset_stb", i_stb, 0);
        check("reset_we", i_we, 0);
        check("reset_tgc", i_tgc, 0);
        check("reset_sel", i_sel, 0);
        check("reset_adr", i_adr, 0);
        check("reset_dat_w", i_dat_w, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_err", rsp_err, 0);
        check("reset_rsp_dat", rsp_dat, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_req_ready", req_ready, 1);

        // Responses outside BUS are ignored
        i_ack = 1'b1;
        i_err = 1'b1;
        @(negedge clock);
        i_ack = 1'b0;
        i_err = 1'b0;
        check("stray_rsp_valid", rsp_valid, 0);
        check("stray_req_ready", req_ready, 1);
        check("stray_cyc", i_cyc, 0);

        // Plain write, immediate ack
        issue(32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 4'h0, 1'b1, 4'hF);
        target_respond(0, 1'b1, 1'b0, 32'h0);
        take_response(0);

        // Plain read, three wait cycles
        issue(32'h104, 32'h0, 1'b0, 4'hF, 4'h0, 1'b0, 4'hF);
        target_respond(3, 1'b1, 1'b0, 32'h12345678);
        take_response(0);

        // AMO ADD: forced write, full byte enables
        issue(32'h200, 32'h5, 1'b0, 4'h1, AMO_ADD, 1'b1, 4'hF);
        target_respond(0, 1'b1, 1'b0, 32'h7);
        take_response(0);

        // ack and err together, response back-pressured for 4 cycles
        issue(32'h300, 32'h0, 1'b0, 4'h3, 4'h0, 1'b0, 4'h3);
        target_respond(1, 1'b1, 1'b1, 32'hA5A5A5A5);
        take_response(4);

        // Silent target
        issue(32'h400, 32'h0, 1'b0, 4'hF, 4'h0, 1'b0, 4'hF);
`ifdef FW_WB_AMO_INIT_TIMEOUT_EN
        n = 0;
        while (i_cyc && n < 100) begin
            n++;
            @(negedge clock);
        end
        check("timeout_bus_cycles", n, TO);
        check("timeout_rsp_valid", rsp_valid, 1);
        sb.push_back('{dat: '0, err: 1'b1});
        take_response(0);
`else
        n = 0;
        while (i_cyc && n < 1000) begin
            n++;
            @(negedge clock);
        end
        check("no_timeout_cyc_held", n, 1000);
        check("no_timeout_rsp_valid", rsp_valid, 0);
        pulse_reset();
`endif

        // Reset mid-BUS abandons the transaction
        issue(32'h500, 32'h11, 1'b1, 4'hF, 4'h0, 1'b1, 4'hF);
        @(negedge clock);
        pulse_reset();
        check("abandon_sb_empty", sb.size(), 0);
        check("abandon_req_ready", req_ready, 1);

        // Next command runs normally
        issue(32'h108, 32'h0, 1'b0, 4'hF, 4'h0, 1'b0, 4'hF);
        target_respond(2, 1'b1, 1'b0, 32'hCAFEF00D);
        take_response(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
